// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the riscv-formal check sequencer.
package rvfi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int CNT_W_DEFAULT = 16;

  // Adds two counts and clamps the sum at max_val, so a counter never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/rvfi_popcount.sv
// Counts how many of the NRET retirement channels are valid in the current cycle.
module rvfi_popcount #(
  parameter int NRET = 1,
  localparam int OUT_W = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]  valid,
  output logic [OUT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NRET; i++) begin
      count = count + OUT_W'(valid[i]);
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Drives checker reset/trig/check strobes, counts retirements and flags a hang.
// Optional early check when RVFI_SEQ_EARLY_CHECK_EN is defined.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int NRET         = 1,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int RESET_CYCLES = 1,
  parameter int TRIG_CYCLE   = 10,
  parameter int CHECK_CYCLE  = 20,
  parameter int MIN_RET      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NRET-1:0]  rvfi_valid,
  output logic             chk_reset,
  output logic             chk_trig,
  output logic             chk_check,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle,
  output logic             done,
  output logic             hang
);

  localparam int POP_W = $clog2(NRET + 1);
  localparam int RST_W = ($clog2(RESET_CYCLES) < 1) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RESET_CYCLES - 1);
  localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0]      MIN_RET_U = 32'(MIN_RET);
  localparam logic [CNT_W-1:0] TRIG_AT   = CNT_W'(TRIG_CYCLE);
  localparam logic [CNT_W-1:0] CHECK_AT  = CNT_W'(CHECK_CYCLE);
`ifdef RVFI_SEQ_EARLY_CHECK_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  if (TRIG_CYCLE > CHECK_CYCLE) begin : g_bad_trig
    $error("rvfi_check_sequencer: TRIG_CYCLE must not exceed CHECK_CYCLE");
  end
  if (RESET_CYCLES == 0) begin : g_bad_reset
    $error("rvfi_check_sequencer: RESET_CYCLES must be at least 1");
  end
  if (longint'(CHECK_CYCLE) >= (longint'(1) << CNT_W)) begin : g_bad_check
    $error("rvfi_check_sequencer: CHECK_CYCLE does not fit in CNT_W bits");
  end

  seq_state_t       state, state_next;
  logic [RST_W-1:0] rst_cnt, rst_cnt_next;
  logic [CNT_W-1:0] cycle_next, retire_next, cycle_inc, retire_sum;
  logic [POP_W-1:0] pop;
  logic             chk_reset_next, chk_trig_next, chk_check_next, done_next, hang_next;
  logic             early_hit;

  rvfi_popcount #(.NRET(NRET)) u_popcount (
    .valid (rvfi_valid),
    .count (pop)
  );

  assign cycle_inc  = cycle + CNT_W'(1);
  assign retire_sum = CNT_W'(sat_add(32'(retire_count), 32'(pop), CNT_MAX));
  // Early check looks at the count as it will be registered in the next cycle.
  assign early_hit  = EARLY_EN && (cycle_inc >= TRIG_AT) && (32'(retire_sum) >= MIN_RET_U);

  // Strobes are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_next     = state;
    rst_cnt_next   = rst_cnt;
    cycle_next     = cycle;
    retire_next    = retire_count;
    chk_reset_next = chk_reset;
    chk_trig_next  = 1'b0;
    chk_check_next = 1'b0;
    done_next      = done;
    hang_next      = hang;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next     = RST;
          rst_cnt_next   = RST_LOAD;
          cycle_next     = '0;
          retire_next    = '0;
          hang_next      = 1'b0;
          done_next      = 1'b0;
          chk_reset_next = 1'b1;
        end
      end
      RST: begin
        if (rst_cnt == '0) begin
          state_next     = RUN;
          chk_reset_next = 1'b0;
          chk_trig_next  = (TRIG_CYCLE == 0);
          chk_check_next = (CHECK_CYCLE == 0) ||
                           (EARLY_EN && (TRIG_CYCLE == 0) && (MIN_RET_U == 32'd0));
        end else begin
          rst_cnt_next = rst_cnt - RST_W'(1);
        end
      end
      RUN: begin
        retire_next = retire_sum;
        // The registered chk_check marks the check cycle; its own retirements are excluded.
        if (chk_check) begin
          state_next = DONE;
          done_next  = 1'b1;
          hang_next  = (32'(retire_count) < MIN_RET_U);
        end else begin
          cycle_next     = cycle_inc;
          chk_trig_next  = (cycle_inc == TRIG_AT);
          chk_check_next = (cycle_inc == CHECK_AT) || early_hit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      chk_reset    <= 1'b1;
      chk_trig     <= 1'b0;
      chk_check    <= 1'b0;
      retire_count <= '0;
      cycle        <= '0;
      done         <= 1'b0;
      hang         <= 1'b0;
    end else begin
      state        <= state_next;
      rst_cnt      <= rst_cnt_next;
      chk_reset    <= chk_reset_next;
      chk_trig     <= chk_trig_next;
      chk_check    <= chk_check_next;
      retire_count <= retire_next;
      cycle        <= cycle_next;
      done         <= done_next;
      hang         <= hang_next;
    end
  end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: three configurations checked every cycle against
// a time-based behavioural model, plus literal expectations for the directed scenarios.
module tb_rvfi_check_sequencer;

  localparam int NI = 3;
  localparam int P_RC    [NI] = '{1, 3, 2};
  localparam int P_TRIG  [NI] = '{10, 5, 5};
  localparam int P_CHECK [NI] = '{20, 14, 5};
  localparam int P_MIN   [NI] = '{1, 16, 1};
  localparam int P_MAX   [NI] = '{65535, 15, 65535};
`ifdef RVFI_SEQ_EARLY_CHECK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int EXP_CHK_S1 = EARLY ? 10 : 20;
  localparam int EXP_CHK_S6 = EARLY ? 13 : 20;

  typedef struct {
    int phase;
    int rst;
    int cyc;
    int rc;
    bit hang;
  } mstate_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [0:0]  va, vc;
  logic [1:0]  vb;
  logic        act_reset[NI], act_trig[NI], act_check[NI], act_done[NI], act_hang[NI];
  logic [15:0] rc_a, cyc_a, rc_c, cyc_c;
  logic [3:0]  rc_b, cyc_b;
  int          act_rc[NI], act_cyc[NI];
  mstate_t     ms[NI];
  int          mode[NI];
  int          trig_at[NI], check_at[NI], check_pulses[NI];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  assign act_rc[0]  = int'(rc_a);
  assign act_rc[1]  = int'(rc_b);
  assign act_rc[2]  = int'(rc_c);
  assign act_cyc[0] = int'(cyc_a);
  assign act_cyc[1] = int'(cyc_b);
  assign act_cyc[2] = int'(cyc_c);

  rvfi_check_sequencer #(.NRET(1), .CNT_W(16), .RESET_CYCLES(P_RC[0]), .TRIG_CYCLE(P_TRIG[0]),
                         .CHECK_CYCLE(P_CHECK[0]), .MIN_RET(P_MIN[0])) dut_a (
    .clock(clock), .reset(reset), .start(start), .rvfi_valid(va),
    .chk_reset(act_reset[0]), .chk_trig(act_trig[0]), .chk_check(act_check[0]),
    .retire_count(rc_a), .cycle(cyc_a), .done(act_done[0]), .hang(act_hang[0]));

  rvfi_check_sequencer #(.NRET(2), .CNT_W(4), .RESET_CYCLES(P_RC[1]), .TRIG_CYCLE(P_TRIG[1]),
                         .CHECK_CYCLE(P_CHECK[1]), .MIN_RET(P_MIN[1])) dut_b (
    .clock(clock), .reset(reset), .start(start), .rvfi_valid(vb),
    .chk_reset(act_reset[1]), .chk_trig(act_trig[1]), .chk_check(act_check[1]),
    .retire_count(rc_b), .cycle(cyc_b), .done(act_done[1]), .hang(act_hang[1]));

  rvfi_check_sequencer #(.NRET(1), .CNT_W(16), .RESET_CYCLES(P_RC[2]), .TRIG_CYCLE(P_TRIG[2]),
                         .CHECK_CYCLE(P_CHECK[2]), .MIN_RET(P_MIN[2])) dut_c (
    .clock(clock), .reset(reset), .start(start), .rvfi_valid(vc),
    .chk_reset(act_reset[2]), .chk_trig(act_trig[2]), .chk_check(act_check[2]),
    .retire_count(rc_c), .cycle(cyc_c), .done(act_done[2]), .hang(act_hang[2]));

  // Model phases: 0 idle, 1 reset window, 2 run, 3 done.
  function automatic bit exp_trig(int i, mstate_t s);
    return (s.phase == 2) && (s.cyc == P_TRIG[i]);
  endfunction

  function automatic bit exp_check(int i, mstate_t s);
    return (s.phase == 2) &&
           ((s.cyc == P_CHECK[i]) || (EARLY && (s.cyc >= P_TRIG[i]) && (s.rc >= P_MIN[i])));
  endfunction

  function automatic mstate_t model_next(int i, mstate_t s, bit st, int p);
    mstate_t n;
    n = s;
    if (s.phase == 0 || s.phase == 3) begin
      if (st) begin
        n.phase = 1;
        n.rst   = P_RC[i] - 1;
        n.cyc   = 0;
        n.rc    = 0;
        n.hang  = 1'b0;
      end
    end else if (s.phase == 1) begin
      if (s.rst == 0) n.phase = 2;
      else n.rst = s.rst - 1;
    end else begin
      n.rc = (s.rc + p > P_MAX[i]) ? P_MAX[i] : s.rc + p;
      if (exp_check(i, s)) begin
        n.phase = 3;
        n.hang  = (s.rc < P_MIN[i]);
      end else begin
        n.cyc = s.cyc + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) ms[i] <= '{phase: 0, rst: 0, cyc: 0, rc: 0, hang: 1'b0};
    end else begin
      ms[0] <= model_next(0, ms[0], start, $countones(va));
      ms[1] <= model_next(1, ms[1], start, $countones(vb));
      ms[2] <= model_next(2, ms[2], start, $countones(vc));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("chk_reset[%0d]", i), int'(act_reset[i]), int'(ms[i].phase <= 1));
      checkOutput($sformatf("chk_trig[%0d]", i), int'(act_trig[i]), int'(exp_trig(i, ms[i])));
      checkOutput($sformatf("chk_check[%0d]", i), int'(act_check[i]), int'(exp_check(i, ms[i])));
      checkOutput($sformatf("done[%0d]", i), int'(act_done[i]), int'(ms[i].phase == 3));
      checkOutput($sformatf("hang[%0d]", i), int'(act_hang[i]), int'(ms[i].hang));
      checkOutput($sformatf("retire_count[%0d]", i), act_rc[i], ms[i].rc);
      checkOutput($sformatf("cycle[%0d]", i), act_cyc[i], ms[i].cyc);
      if (act_trig[i] === 1'b1) trig_at[i] = act_cyc[i];
      if (act_check[i] === 1'b1) begin
        check_at[i] = act_cyc[i];
        check_pulses[i]++;
      end
    end
  end

  function automatic int pick(int m, mstate_t s, int width);
    bit run;
    run = (s.phase == 2);
    case (m)
      1:       return (run && (s.cyc == 3 || s.cyc == 7)) ? 1 : 0;
      2:       return int'($urandom_range((1 << width) - 1, 0));
      3:       return (run && s.cyc == 12) ? 1 : 0;
      4:       return run ? (1 << width) - 1 : 0;
      5:       return (run && s.cyc == 5) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic driveCycle(input bit st);
    @(negedge clock);
    start = st;
    va = 1'(pick(mode[0], ms[0], 1));
    vb = 2'(pick(mode[1], ms[1], 2));
    vc = 1'(pick(mode[2], ms[2], 1));
  endtask

  task automatic waitDone(input string tag);
    int budget;
    budget = 100;
    while (!(act_done[0] && act_done[1] && act_done[2]) && budget > 0) begin
      driveCycle(1'b0);
      budget--;
    end
    checkOutput({tag, "_done_in_time"}, int'(budget > 0), 1);
  endtask

  task automatic applyStimulus(input int ma, input int mb, input int mc, input string tag);
    mode[0] = ma;
    mode[1] = mb;
    mode[2] = mc;
    for (int i = 0; i < NI; i++) begin
      trig_at[i]      = -1;
      check_at[i]     = -1;
      check_pulses[i] = 0;
    end
    driveCycle(1'b1);
    driveCycle(1'b0);
    waitDone(tag);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_chk_reset"}, int'(act_reset[0]), 1);
    checkOutput({tag, "_chk_trig"}, int'(act_trig[0]), 0);
    checkOutput({tag, "_chk_check"}, int'(act_check[0]), 0);
    checkOutput({tag, "_retire_count"}, act_rc[0], 0);
    checkOutput({tag, "_cycle"}, act_cyc[0], 0);
    checkOutput({tag, "_done"}, int'(act_done[0]), 0);
    checkOutput({tag, "_hang"}, int'(act_hang[0]), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    reset = 1'b1;
    start = 1'b0;
    va = '0;
    vb = '0;
    vc = '0;
    for (int i = 0; i < NI; i++) mode[i] = 0;
    driveCycle(1'b0);
    driveCycle(1'b0);
    checkResetValues("por");
    reset = 1'b0;

    // Two retirements, then the saturating and same-cycle-strobe configurations.
    applyStimulus(1, 4, 5, "s1");
    checkOutput("s1_a_trig_at", trig_at[0], 10);
    checkOutput("s1_a_check_at", check_at[0], EXP_CHK_S1);
    checkOutput("s1_a_retire_count", act_rc[0], 2);
    checkOutput("s1_a_hang", int'(act_hang[0]), 0);
    checkOutput("s1_b_retire_sat", act_rc[1], 15);
    checkOutput("s1_b_hang", int'(act_hang[1]), 1);
    checkOutput("s1_c_trig_at", trig_at[2], 5);
    checkOutput("s1_c_check_at", check_at[2], 5);
    checkOutput("s1_c_hang_same_cycle", int'(act_hang[2]), 1);
    checkOutput("s1_c_retire_count", act_rc[2], 1);

    // No retirements at all: restart from DONE and expect a hang.
    applyStimulus(0, 2, 2, "s2");
    checkOutput("s2_a_check_at", check_at[0], 20);
    checkOutput("s2_a_hang", int'(act_hang[0]), 1);
    checkOutput("s2_a_retire_count", act_rc[0], 0);

    // Single late retirement after the trigger.
    applyStimulus(3, 2, 2, "s6");
    checkOutput("s6_a_check_at", check_at[0], EXP_CHK_S6);
    checkOutput("s6_a_hang", int'(act_hang[0]), 0);
    checkOutput("s6_a_retire_count", act_rc[0], 1);

    // Async reset in the middle of RUN cycle 12, then a clean restart.
    mode[0] = 0;
    mode[1] = 2;
    mode[2] = 2;
    for (int i = 0; i < NI; i++) check_pulses[i] = 0;
    driveCycle(1'b1);
    budget = 60;
    while (!(ms[0].phase == 2 && ms[0].cyc == 12) && budget > 0) begin
      driveCycle(1'b0);
      budget--;
    end
    checkOutput("s4_reached_cycle12", int'(budget > 0), 1);
    #2 reset = 1'b1;
    #1 checkResetValues("s4_async");
    checkOutput("s4_no_check_pulse", check_pulses[0], 0);
    driveCycle(1'b0);
    driveCycle(1'b0);
    reset = 1'b0;
    applyStimulus(2, 2, 2, "s4_restart");
    checkOutput("s4_restart_one_check", check_pulses[0], 1);
    checkOutput("s4_restart_done", int'(act_done[0]), 1);

    // Random start requests and retirements, checked cycle by cycle against the model.
    mode[0] = 2;
    mode[1] = 2;
    mode[2] = 2;
    for (int n = 0; n < 300; n++) driveCycle($urandom_range(7, 0) == 0);
    driveCycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
